// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler
// Sequential FIR filter: one sample is accepted at a time, then the TAPS
// products x[i]*c[i] are formed on a single shared multiplier, one tap per
// cycle. The result is held until the consumer takes it.
//
// The multiplier output is registered (prod_r), so MAC takes TAPS+1 edges:
// the first MAC edge only loads prod_r, and the last one folds the final
// product into the result while moving to HOLD.

module fir_tap_scheduler #(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int ACCW = DW + CW + $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      cfg_we,
  input  logic [$clog2(TAPS)-1:0]   cfg_addr,
  input  logic [CW-1:0]             cfg_data,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACCW-1:0]           out_data,
  output logic                      busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DW + CW;
  // Tap counter is one bit wider than the index so it can reach TAPS,
  // which marks the drain edge of the product pipeline.
  localparam logic [AW:0] TAP_END = (AW + 1)'(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_r;
  logic [AW:0]             tap_r;
  logic signed [DW-1:0]    x_r [TAPS];
  logic signed [CW-1:0]    c_r [TAPS];
  logic signed [PW-1:0]    prod_r;
  logic signed [ACCW-1:0]  acc_r;
  logic signed [ACCW-1:0]  out_data_r;
  logic                    out_valid_r;

  logic [AW-1:0]           tap_idx_s;
  logic                    tap_live_s;
  logic signed [PW-1:0]    mult_s;
  logic signed [ACCW-1:0]  prod_ext_s;
  logic signed [ACCW-1:0]  acc_next_s;
  logic                    accept_s;
  logic                    cfg_ok_s;

  assign tap_idx_s  = tap_r[AW-1:0];
  assign tap_live_s = (tap_r < TAP_END);
  assign accept_s   = ena & in_valid & (state_r == IDLE);
  assign cfg_ok_s   = ena & cfg_we & (state_r == IDLE);

  // Shared multiplier: full-precision signed product of the current tap,
  // forced to zero once every tap has been issued.
  always_comb begin
    mult_s = {PW{1'b0}};
    if (tap_live_s) begin
      mult_s = x_r[tap_idx_s] * c_r[tap_idx_s];
    end else begin
      mult_s = {PW{1'b0}};
    end
  end

  // Sign-extend the registered product and form the next accumulator value.
  always_comb begin
    prod_ext_s = ACCW'(prod_r);
    acc_next_s = acc_r + prod_ext_s;
  end

  // Coefficient bank: writable only in IDLE while enabled. A write on the
  // accepting edge lands before the first multiply, so it is used at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        c_r[k] <= {CW{1'b0}};
      end
    end else if (cfg_ok_s) begin
      c_r[cfg_addr] <= cfg_data;
    end
  end

  // Sample delay line: shifts by one position on every accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= {DW{1'b0}};
      end
    end else if (accept_s) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        x_r[k] <= x_r[k-1];
      end
      x_r[0] <= in_data;
    end
  end

  // Scheduler FSM with tap counter, product pipeline, accumulator and
  // registered result; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      tap_r       <= {(AW + 1){1'b0}};
      prod_r      <= {PW{1'b0}};
      acc_r       <= {ACCW{1'b0}};
      out_data_r  <= {ACCW{1'b0}};
      out_valid_r <= 1'b0;
    end else if (ena) begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r <= MAC;
            tap_r   <= {(AW + 1){1'b0}};
            prod_r  <= {PW{1'b0}};
            acc_r   <= {ACCW{1'b0}};
          end
        end
        MAC: begin
          acc_r  <= acc_next_s;
          prod_r <= mult_s;
          if (tap_r == TAP_END) begin
            state_r     <= HOLD;
            out_data_r  <= acc_next_s;
            out_valid_r <= 1'b1;
          end else begin
            tap_r <= tap_r + (AW + 1)'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ena & (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Bench for fir_tap_scheduler: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-level model that computes
// each result as a plain dot product at the moment a sample is accepted.

module tb_fir_tap_scheduler;

  localparam int TAPS = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int AW   = 2;
  localparam int ACCW = 18;

  logic            clk;
  logic            rst_n;
  logic            ena;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [CW-1:0]   cfg_data;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic            busy;

  int checks;
  int failures;

  // Model: 0 = waiting for sample, 1 = computing, 2 = result on offer
  int     m_mode;
  int     m_cnt;
  int     m_hist [TAPS];
  int     m_coef [TAPS];
  longint m_result;
  longint m_out_data;
  bit     m_out_valid;

  fir_tap_scheduler #(.TAPS(TAPS), .DW(DW), .CW(CW), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: no out_valid within cycle budget at %0t", nm, $time);
  endtask

  task automatic m_reset();
    m_mode = 0;
    m_cnt = 0;
    m_result = 0;
    m_out_data = 0;
    m_out_valid = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      m_hist[k] = 0;
      m_coef[k] = 0;
    end
  endtask

  task automatic compare_all();
    chk("in_ready", longint'(in_ready), longint'((m_mode == 0) && ena));
    chk("busy", longint'(busy), longint'(m_mode != 0));
    chk("out_valid", longint'(out_valid), longint'(m_out_valid));
    chk("out_data", longint'($signed(out_data)), m_out_data);
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs shortly after it.
  task automatic tick();
    @(posedge clk);
    if (rst_n && ena) begin
      case (m_mode)
        0: begin
          if (cfg_we) m_coef[cfg_addr] = int'($signed(cfg_data));
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = int'($signed(in_data));
            m_result = 0;
            for (int k = 0; k < TAPS; k++)
              m_result += longint'(m_hist[k]) * longint'(m_coef[k]);
            m_mode = 1;
            m_cnt = 0;
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt == TAPS + 1) begin
            m_mode = 2;
            m_out_valid = 1'b1;
            m_out_data = m_result;
          end
        end
        default: begin
          if (out_ready) begin
            m_mode = 0;
            m_out_valid = 1'b0;
          end
        end
      endcase
    end
    #1;
    compare_all();
  endtask

  task automatic set_coef(input int addr, input int val);
    cfg_we = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = CW'(val);
    tick();
    cfg_we = 1'b0;
  endtask

  // Offer one sample, wait for its result, optionally pin it to a literal,
  // check latency and take the result. mid_wr writes c[0]=50 on the first
  // MAC edge, which must have no effect.
  task automatic send(input int sample, input bit has_lit, input longint lit,
                      input bit mid_wr);
    int cnt;
    bit got;
    in_valid = 1'b1;
    in_data = DW'(sample);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      cfg_we = mid_wr && (cnt == 0);
      cfg_addr = 2'd0;
      cfg_data = 8'd50;
      tick();
      cnt++;
      if (out_valid) got = 1'b1;
    end
    cfg_we = 1'b0;
    if (!got) begin
      timeout_fail("send_wait");
    end else begin
      if (has_lit) chk("result_literal", longint'($signed(out_data)), lit);
      chk("latency", longint'(cnt), longint'(TAPS + 1));
    end
    tick();
  endtask

  initial begin
    int cnt;
    bit got;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 8'd0;
    in_valid = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b0;
    m_reset();
    #2;
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Impulse response
    set_coef(0, 1); set_coef(1, 2); set_coef(2, 3); set_coef(3, 4);
    send(1, 1'b1, 64'sd1, 1'b0);
    send(0, 1'b1, 64'sd2, 1'b0);
    send(0, 1'b1, 64'sd3, 1'b0);
    send(0, 1'b1, 64'sd4, 1'b0);
    send(0, 1'b1, 64'sd0, 1'b0);

    // Extreme negative operands, no wrap
    for (int k = 0; k < TAPS; k++) set_coef(k, -128);
    send(-128, 1'b1, 64'sd16384, 1'b0);
    send(-128, 1'b0, 64'sd0, 1'b0);
    send(-128, 1'b0, 64'sd0, 1'b0);
    send(-128, 1'b1, 64'sd65536, 1'b0);
    set_coef(0, 127); set_coef(1, -128); set_coef(2, 127); set_coef(3, -128);
    send(127, 1'b0, 64'sd0, 1'b0);
    send(-128, 1'b0, 64'sd0, 1'b0);
    send(127, 1'b0, 64'sd0, 1'b0);
    send(-128, 1'b1, -64'sd65024, 1'b0);

    // Back-pressure: result must stay put while out_ready is low
    in_valid = 1'b1;
    in_data = 8'd5;
    out_ready = 1'b0;
    tick();
    in_data = 8'hF9;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      tick();
      cnt++;
      if (out_valid) got = 1'b1;
    end
    if (!got) timeout_fail("stall_wait");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_value", longint'($signed(out_data)), 64'sd49532);
      chk("hold_valid", longint'(out_valid), 64'sd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Coefficient writes during MAC are ignored, in IDLE they apply
    set_coef(0, 7); set_coef(1, 0); set_coef(2, 0); set_coef(3, 0);
    send(2, 1'b1, 64'sd14, 1'b1);
    send(3, 1'b1, 64'sd21, 1'b0);
    set_coef(0, 50);
    send(1, 1'b1, 64'sd50, 1'b0);

    // Enable dropped for three cycles mid-MAC
    in_valid = 1'b1;
    in_data = 8'd2;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      ena = !(cnt >= 2 && cnt < 5);
      tick();
      cnt++;
      if (out_valid) got = 1'b1;
    end
    ena = 1'b1;
    if (!got) begin
      timeout_fail("ena_wait");
    end else begin
      chk("ena_result", longint'($signed(out_data)), 64'sd100);
      chk("ena_latency", longint'(cnt), longint'(TAPS + 4));
    end
    tick();

    // Reset in the second MAC cycle abandons the computation
    in_valid = 1'b1;
    in_data = 8'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    chk("rst_out_data", longint'($signed(out_data)), 64'sd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    send(1, 1'b1, 64'sd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ena = ($urandom_range(7) != 0);
      in_valid = $urandom_range(1);
      in_data = DW'($urandom);
      cfg_we = ($urandom_range(3) == 0);
      cfg_addr = AW'($urandom);
      cfg_data = CW'($urandom);
      out_ready = $urandom_range(1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tap_scheduler.md
FIR_TAP_SCHEDULER -- requirements
Module: fir_tap_scheduler

Interface
REQ-001 SHALL have parameter TAPS, default 4, number of filter taps (power of two, 2..16).
REQ-002 SHALL have parameter DW, default 8, signed sample width.
REQ-003 SHALL have parameter CW, default 8, signed coefficient width.
REQ-004 SHALL have parameter ACCW, default DW+CW+log2(TAPS) (18), accumulator/output width.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port ena, input, 1, global enable; low freezes all state.
REQ-008 SHALL have port cfg_we, input, 1, coefficient write strobe.
REQ-009 SHALL have port cfg_addr, input, log2(TAPS), coefficient index.
REQ-010 SHALL have port cfg_data, input, CW, coefficient value (two's complement).
REQ-011 SHALL have port in_valid, input, 1, sample offered.
REQ-012 SHALL have port in_data, input, DW, sample value (two's complement).
REQ-013 SHALL have port in_ready, output, 1, scheduler accepts a sample.
REQ-014 SHALL have port out_valid, output, 1, result available.
REQ-015 SHALL have port out_ready, input, 1, consumer takes result.
REQ-016 SHALL have port out_data, output, ACCW, filter result y[n] (two's complement).
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, MAC, HOLD; one shared multiplier, one tap per cycle.
REQ-019 SHALL drive in_ready = 1 only in IDLE with ena = 1.
REQ-020 SHALL, on an edge with in_valid & in_ready, shift the delay line (x[k] <- x[k-1], x[0] <- in_data), clear tap index and accumulator, and enter MAC.
REQ-021 SHALL, in MAC, add the full-precision signed product x[i]*c[i] to the accumulator per cycle for i = 0..TAPS-1, then enter HOLD after the last tap.
REQ-022 SHALL, in HOLD, present out_data = sum of all TAPS products with out_valid = 1, both held stable until out_ready = 1.
REQ-023 SHALL, on an edge in HOLD with out_ready = 1, drop out_valid and return to IDLE; a new sample is accepted no earlier than the following edge.
REQ-024 SHALL assert out_valid exactly TAPS+1 enabled edges after the accepting edge (5 for TAPS = 4).
REQ-025 SHALL use signed arithmetic sized to ACCW so no overflow or wrap occurs for any input/coefficient combination.
REQ-026 SHALL write cfg_data to c[cfg_addr] on an edge with cfg_we = 1 only in IDLE; writes in MAC or HOLD are ignored.
REQ-027 SHALL give a simultaneous cfg_we and sample accept in IDLE write the coefficient on that edge; that coefficient is used by the computation just started.
REQ-028 SHALL, while ena = 0, hold FSM, tap index, accumulator, delay line, coefficients and outputs unchanged, force in_ready = 0, and ignore cfg_we.
REQ-029 SHALL keep out_data at its last result outside HOLD; out_data is only meaningful when out_valid = 1.

Reset
REQ-030 SHALL, on rst_n = 0, immediately enter IDLE, clear delay line, coefficients, accumulator and tap index, and drive out_valid = 0, out_data = 0, busy = 0.
REQ-031 SHALL, on rst_n = 0 mid-MAC or in HOLD, abandon the computation with no out_valid pulse; in_ready = 1 on the first enabled cycle after release.

Verification
REQ-032 SHALL cover: c = {1,2,3,4}, samples 1,0,0,0,0 with out_ready = 1 -> out_data 1,2,3,4,0.
REQ-033 SHALL cover: all c = -128, four samples -128 -> final out_data = 65536 without wrap; c = {127,-128,127,-128}, samples alternating 127/-128 -> exact signed sums.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in HOLD -> out_valid and out_data stable, in_ready = 0, in_valid ignored.
REQ-035 SHALL cover: cfg_we to c[0] = 50 during MAC -> current and next result use old c[0]; same write in IDLE -> next result uses 50.
REQ-036 SHALL cover: rst_n pulsed low on second MAC cycle -> no out_valid, outputs 0, next impulse returns c[0] = 0 (coefficients cleared).
REQ-037 SHALL cover: ena = 0 for 3 cycles mid-MAC -> out_valid asserts exactly 3 cycles later than nominal, value unchanged.
